pixel_window_generator: RTL and testbench

PIXEL_WINDOW_GENERATOR -- requirements
Module: pixel_window_generator

---
 rtl/pixel_window_generator.sv | 177 +++++++++++++++++
 tb/tb_pixel_window_generator.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_generator.sv
// ---------------------------------------------------------------------------
// pixel_window_generator
//
// Purpose:
//   Turns a raster-order RGB pixel stream into a stream of 3x3 neighbourhood
//   windows, one per pixel whose 3x3 neighbourhood lies fully inside the
//   frame (no border padding). Two line buffers hold the previous two rows.
//   A 3x3 shift register tracks the last three columns of the three rows.
//
// Parameters:
//   IMG_WIDTH   active pixels per line
//   IMG_HEIGHT  lines per frame
//   PIX_WIDTH   bits per colour sample
//
// Ports:
//   clk                  sole clock, rising edge
//   reset                synchronous, active-high
//   in_valid / in_ready  input handshake; in_ready = !out_valid || out_ready
//   in_sof               the pixel on this transfer is frame pixel (0,0)
//   in_r, in_g, in_b     colour samples, raster order
//   out_valid/out_ready  output handshake
//   r/g/b_window         3x3 windows; element [i][j] at (i*3+j)*PIX_WIDTH;
//                        row 0 = line y-2, column 0 = pixel x-2
//   out_x, out_y         window centre coordinates
// ---------------------------------------------------------------------------
module pixel_window_generator #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_WIDTH  = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [PIX_WIDTH-1:0]   in_r,
  input  logic [PIX_WIDTH-1:0]   in_g,
  input  logic [PIX_WIDTH-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*PIX_WIDTH-1:0] r_window,
  output logic [9*PIX_WIDTH-1:0] g_window,
  output logic [9*PIX_WIDTH-1:0] b_window,
  output logic [15:0]            out_x,
  output logic [15:0]            out_y
);

  localparam int          PW3    = 3 * PIX_WIDTH;
  localparam int          XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  // A pixel is stored as {r, g, b}.
  typedef logic [PW3-1:0] pix_t;

  logic [15:0]            x_q, x_d;
  logic [15:0]            y_q, y_d;
  logic [15:0]            cur_x, cur_y;
  logic [2:0][2:0][PW3-1:0] win_q, win_d;
  logic                   out_valid_q, out_valid_d;
  logic [9*PIX_WIDTH-1:0] r_window_q, r_window_d;
  logic [9*PIX_WIDTH-1:0] g_window_q, g_window_d;
  logic [9*PIX_WIDTH-1:0] b_window_q, b_window_d;
  logic [15:0]            out_x_q, out_x_d;
  logic [15:0]            out_y_q, out_y_d;

  pix_t                   buf1_mem [IMG_WIDTH];
  pix_t                   buf2_mem [IMG_WIDTH];

  logic [XW-1:0]          x_idx;
  pix_t                   new_pix;
  pix_t                   tap1;
  pix_t                   tap2;
  logic                   in_xfer;
  logic                   emit;

  // Input is only stalled when a window is pending and not being taken,
  // so a newly completed window can never overwrite one still on offer.
  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // A start-of-frame pixel overrides the running counters.
  assign cur_x   = in_sof ? 16'd0 : x_q;
  assign cur_y   = in_sof ? 16'd0 : y_q;
  assign x_idx   = cur_x[XW-1:0];
  assign new_pix = {in_r, in_g, in_b};
  assign tap1    = buf1_mem[x_idx];
  assign tap2    = buf2_mem[x_idx];
  assign emit    = in_xfer && (cur_x >= 16'd2) && (cur_y >= 16'd2);

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    win_d       = win_q;
    out_valid_d = out_valid_q && !out_ready;
    r_window_d  = r_window_q;
    g_window_d  = g_window_q;
    b_window_d  = b_window_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;

    if (in_xfer) begin
      if (cur_x == X_LAST) begin
        x_d = 16'd0;
        y_d = (cur_y == Y_LAST) ? 16'd0 : cur_y + 16'd1;
      end else begin
        x_d = cur_x + 16'd1;
        y_d = cur_y;
      end

      // Shift left by one column; column 2 gets the oldest row at row 0.
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = tap2;
      win_d[1][2] = tap1;
      win_d[2][2] = new_pix;
    end

    // The window is built from the freshly shifted contents so that it
    // appears on the cycle after the completing transfer.
    if (emit) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_window_d[(i*3+j)*PIX_WIDTH +: PIX_WIDTH] = win_d[i][j][PW3-1 -: PIX_WIDTH];
          g_window_d[(i*3+j)*PIX_WIDTH +: PIX_WIDTH] = win_d[i][j][2*PIX_WIDTH-1 -: PIX_WIDTH];
          b_window_d[(i*3+j)*PIX_WIDTH +: PIX_WIDTH] = win_d[i][j][PIX_WIDTH-1:0];
        end
      end
      out_x_d = cur_x - 16'd1;
      out_y_d = cur_y - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      r_window_q  <= '0;
      g_window_q  <= '0;
      b_window_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      r_window_q  <= r_window_d;
      g_window_q  <= g_window_d;
      b_window_q  <= b_window_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  // Line buffers carry no reset: rows y-1 and y-2 are always rewritten
  // before any window that reads them can be emitted.
  always_ff @(posedge clk) begin
    if (in_xfer && !reset) begin
      buf1_mem[x_idx] <= new_pix;
      buf2_mem[x_idx] <= tap1;
    end
  end

  assign out_valid = out_valid_q;
  assign r_window  = r_window_q;
  assign g_window  = g_window_q;
  assign b_window  = b_window_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_pixel_window_generator.sv
// ---------------------------------------------------------------------------
// tb_pixel_window_generator
//
// Purpose:
//   Self-checking bench for pixel_window_generator on a 4x4 image with 9-bit
//   samples. A reference model stores every accepted pixel into an image
//   array at its frame coordinate and cuts the expected 3x3 window straight
//   out of that image; observed output transfers are compared in order.
// ---------------------------------------------------------------------------
module tb_pixel_window_generator;

  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 9;

  typedef logic [3*P-1:0] pix_t;
  typedef struct packed {
    logic [9*P-1:0] r;
    logic [9*P-1:0] g;
    logic [9*P-1:0] b;
    logic [15:0]    x;
    logic [15:0]    y;
  } win_t;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           in_sof;
  logic [P-1:0]   in_r, in_g, in_b;
  logic           out_valid;
  logic           out_ready;
  logic [9*P-1:0] r_window, g_window, b_window;
  logic [15:0]    out_x, out_y;

  int   checks;
  int   errors;
  int   mx, my;
  pix_t img [H][W];
  win_t exp_q [$];
  win_t obs_q [$];

  pixel_window_generator #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_WIDTH (P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_window (r_window),
    .g_window (g_window),
    .b_window (b_window),
    .out_x    (out_x),
    .out_y    (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Test pattern: r = 16*y + x, g = r + 100, b = r + 200.
  function automatic pix_t pat(int x, int y);
    int r;
    r = 16 * y + x;
    return {9'(r), 9'(r + 100), 9'(r + 200)};
  endfunction

  // Reference model: place the pixel at its frame coordinate; if a full
  // 3x3 neighbourhood now exists, cut the window out of the image.
  task automatic model_accept(input bit sof, input pix_t p);
    win_t w;
    pix_t q;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = p;
    if (mx >= 2 && my >= 2) begin
      w = '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          q = img[my-2+i][mx-2+j];
          w.r[(i*3+j)*P +: P] = q[3*P-1 -: P];
          w.g[(i*3+j)*P +: P] = q[2*P-1 -: P];
          w.b[(i*3+j)*P +: P] = q[P-1:0];
        end
      end
      w.x = 16'(mx - 1);
      w.y = 16'(my - 1);
      exp_q.push_back(w);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my++;
      if (my == H) my = 0;
    end
  endtask

  // One clock cycle: drive, observe handshake just before the edge, advance.
  task automatic step(input bit v, input bit sof, input pix_t p, input bit o,
                      output bit acc, output bit rdy);
    in_valid  = v;
    in_sof    = sof;
    {in_r, in_g, in_b} = p;
    out_ready = o;
    #1;
    rdy = in_ready;
    acc = v && rdy;
    if (out_valid && o) obs_q.push_back({r_window, g_window, b_window, out_x, out_y});
    if (acc) model_accept(sof, p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc, rdy;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b1, acc, rdy);
  endtask

  // Offers n pixels with random valid/ready duty; a pixel is held until taken.
  task automatic send_pixels(input string name, input int n, input bit sof_first,
                             input int vpct, input int rpct, input bit rnd);
    int   sent;
    bit   held, acc, rdy, v, o, sof;
    pix_t p;
    sent = 0;
    held = 1'b0;
    p    = '0;
    for (int c = 0; c < 40 * n + 100 && sent < n; c++) begin
      v   = ($urandom_range(99) < vpct);
      o   = ($urandom_range(99) < rpct);
      sof = sof_first && (sent == 0);
      if (!held) begin
        p    = rnd ? pix_t'($urandom) : (sof ? pat(0, 0) : pat(mx, my));
        held = 1'b1;
      end
      step(v, sof, p, o, acc, rdy);
      if (acc) begin
        sent++;
        held = 1'b0;
      end
    end
    checks++;
    if (sent != n) begin
      errors++;
      $display("[TB] FAIL %s send_timeout: accepted %0d pixels, required %0d", name, sent, n);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mx = 0;
    my = 0;
    // A window still on offer at reset is discarded.
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sof    = 1'b0;
    in_r      = 9'($urandom);
    in_g      = 9'($urandom);
    in_b      = 9'($urandom);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mx = 0;
    my = 0;
    #1;
    checks += 7;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_x !== 16'd0) begin errors++; $display("[TB] FAIL reset out_x: got %0d want 0", out_x); end
    if (out_y !== 16'd0) begin errors++; $display("[TB] FAIL reset out_y: got %0d want 0", out_y); end
    if (r_window !== '0) begin errors++; $display("[TB] FAIL reset r_window: got %h want 0", r_window); end
    if (g_window !== '0) begin errors++; $display("[TB] FAIL reset g_window: got %h want 0", g_window); end
    if (b_window !== '0) begin errors++; $display("[TB] FAIL reset b_window: got %h want 0", b_window); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    exp_q.delete();
    obs_q.delete();
    send_pixels("full_frame", 11, 1'b1, 100, 100, 1'b0);
    checks += 7;
    if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL full_frame early_window: got %0d windows want 0", obs_q.size()); end
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_frame first_valid: got %b want 1", out_valid); end
    if (r_window[8:0] !== 9'd0) begin errors++; $display("[TB] FAIL full_frame r00: got %0d want 0", r_window[8:0]); end
    if (r_window[44:36] !== 9'd17) begin errors++; $display("[TB] FAIL full_frame r11: got %0d want 17", r_window[44:36]); end
    if (r_window[80:72] !== 9'd34) begin errors++; $display("[TB] FAIL full_frame r22: got %0d want 34", r_window[80:72]); end
    if (out_x !== 16'd1) begin errors++; $display("[TB] FAIL full_frame out_x: got %0d want 1", out_x); end
    if (out_y !== 16'd1) begin errors++; $display("[TB] FAIL full_frame out_y: got %0d want 1", out_y); end
    send_pixels("full_frame", 5, 1'b0, 100, 100, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL full_frame count: got %0d want 4", obs_q.size()); end
    if (obs_q.size() >= 4) begin
      checks++;
      if (obs_q[3].g[80:72] !== 9'd151) begin errors++; $display("[TB] FAIL full_frame last_g22: got %0d want 151", obs_q[3].g[80:72]); end
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL full_frame window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    win_t held;
    bit   acc, rdy;
    exp_q.delete();
    obs_q.delete();
    send_pixels("backpressure", 11, 1'b1, 100, 100, 1'b0);
    held = {r_window, g_window, b_window, out_x, out_y};
    checks++;
    if (exp_q.size() < 1 || held !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL backpressure first_window: got %h want %h", held, (exp_q.size() > 0) ? exp_q[0] : win_t'('0));
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, pat(mx, my), 1'b0, acc, rdy);
      checks += 3;
      if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL backpressure in_ready%0d: got %b want 0", k, rdy); end
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL backpressure hold_valid%0d: got %b want 1", k, out_valid); end
      if ({r_window, g_window, b_window, out_x, out_y} !== held) begin
        errors++;
        $display("[TB] FAIL backpressure hold%0d: got %h want %h", k, {r_window, g_window, b_window, out_x, out_y}, held);
      end
    end
    send_pixels("backpressure", 5, 1'b0, 100, 100, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL backpressure count: got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL backpressure window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_gaps();
    exp_q.delete();
    obs_q.delete();
    send_pixels("random_gaps", 16, 1'b1, 50, 100, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL random_gaps count: got %0d want 4", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0].r[44:36] !== 9'd17) begin errors++; $display("[TB] FAIL random_gaps r11: got %0d want 17", obs_q[0].r[44:36]); end
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_gaps window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    obs_q.delete();
    send_pixels("back_to_back", 16, 1'b1, 100, 100, 1'b0);
    send_pixels("back_to_back", 8, 1'b1, 100, 100, 1'b0);
    checks += 2;
    if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL back_to_back rows01_count: got %0d want 4", obs_q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL back_to_back rows01_valid: got %b want 0", out_valid); end
    send_pixels("back_to_back", 8, 1'b0, 100, 100, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 8) begin errors++; $display("[TB] FAIL back_to_back count: got %0d want 8", obs_q.size()); end
    if (obs_q.size() >= 5 && exp_q.size() >= 1) begin
      checks++;
      if (obs_q[4] !== exp_q[0]) begin errors++; $display("[TB] FAIL back_to_back frame2_first: got %h want %h", obs_q[4], exp_q[0]); end
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL back_to_back window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    exp_q.delete();
    obs_q.delete();
    send_pixels("reset_midframe", 10, 1'b1, 100, 100, 1'b0);
    do_reset();
    send_pixels("reset_midframe", 10, 1'b0, 100, 100, 1'b0);
    checks += 2;
    if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL reset_midframe early_count: got %0d want 0", obs_q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_midframe early_valid: got %b want 0", out_valid); end
    send_pixels("reset_midframe", 1, 1'b0, 100, 100, 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_midframe first_valid: got %b want 1", out_valid); end
    if (out_x !== 16'd1) begin errors++; $display("[TB] FAIL reset_midframe out_x: got %0d want 1", out_x); end
    if (out_y !== 16'd1) begin errors++; $display("[TB] FAIL reset_midframe out_y: got %0d want 1", out_y); end
    send_pixels("reset_midframe", 5, 1'b0, 100, 100, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL reset_midframe count: got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL reset_midframe window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sof_restart();
    exp_q.delete();
    obs_q.delete();
    send_pixels("sof_restart", 7, 1'b1, 100, 100, 1'b0);
    // Original pixel (3,1) arrives flagged as a new frame start.
    send_pixels("sof_restart", 1, 1'b1, 100, 100, 1'b0);
    send_pixels("sof_restart", 9, 1'b0, 100, 100, 1'b0);
    checks += 2;
    if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL sof_restart early_count: got %0d want 0", obs_q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sof_restart early_valid: got %b want 0", out_valid); end
    send_pixels("sof_restart", 1, 1'b0, 100, 100, 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sof_restart first_valid: got %b want 1", out_valid); end
    if (out_x !== 16'd1) begin errors++; $display("[TB] FAIL sof_restart out_x: got %0d want 1", out_x); end
    if (out_y !== 16'd1) begin errors++; $display("[TB] FAIL sof_restart out_y: got %0d want 1", out_y); end
    send_pixels("sof_restart", 5, 1'b0, 100, 100, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL sof_restart count: got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL sof_restart window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_data();
    exp_q.delete();
    obs_q.delete();
    send_pixels("random_data", 3 * W * H, 1'b1, 60, 60, 1'b1);
    idle(4);
    checks++;
    if (obs_q.size() != 12) begin errors++; $display("[TB] FAIL random_data count: got %0d want 12", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_data window%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mx        = 0;
    my        = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_r      = '0;
    in_g      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_gaps();
    test_back_to_back();
    test_reset_midframe();
    test_sof_restart();
    test_random_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
